// File: rtl/bcd_conv_pkg.sv
// Shared types, constants and helpers for the BCD <-> binary converters.
package bcd_conv_pkg;

  // One-hot FSM state for the reverse double-dabble sequencer.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_SUB3  = 3'b100
  } bcd_state_t;

  localparam int unsigned BCD_DIGITS     = 8;
  localparam int unsigned BCD_WIDTH      = 32;
  localparam logic [5:0]  SHIFT_COUNT    = 6'd32;
  localparam logic [3:0]  SUB3_THRESHOLD = 4'd8;

  // Returns 1 when any packed nibble holds a value above 9 (not a decimal digit).
  function automatic logic has_bad_digit(input logic [BCD_WIDTH-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (word[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_sub3_correct.sv
// Per-digit correction step of reverse double-dabble: after a right shift,
// any nibble that received a carried-in weight of 8 is pulled back by 3.
module bcd_sub3_correct
  import bcd_conv_pkg::*;
(
  input  logic [BCD_WIDTH-1:0] din,
  output logic [BCD_WIDTH-1:0] dout
);

  logic [3:0] nib_s;

  // Apply "nibble >= 8 -> nibble - 3" independently to every digit.
  always_comb begin
    dout  = {BCD_WIDTH{1'b0}};
    nib_s = 4'd0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      nib_s = din[4*i +: 4];
      if (nib_s >= SUB3_THRESHOLD) begin
        dout[4*i +: 4] = nib_s - 4'd3;
      end else begin
        dout[4*i +: 4] = nib_s;
      end
    end
  end

endmodule

// File: rtl/bcd_to_unsigned.sv
// Sequential 8-digit BCD to 32-bit binary converter (reverse double-dabble).
// Fixed latency of 63 busy cycles; non-decimal digits force out=0, error=1.
module bcd_to_unsigned
  import bcd_conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic [BCD_WIDTH-1:0] bcd,
  output logic                 idle,
  output logic [BCD_WIDTH-1:0] out,
  output logic                 error
);

  bcd_state_t           state_r;
  logic [BCD_WIDTH-1:0] hi_r;
  logic [BCD_WIDTH-1:0] lo_r;
  logic [5:0]           counter_r;
  logic                 bad_r;
  logic                 idle_r;
  logic [BCD_WIDTH-1:0] out_r;
  logic                 error_r;

  logic [BCD_WIDTH-1:0] shift_hi_s;
  logic [BCD_WIDTH-1:0] shift_lo_s;
  logic [BCD_WIDTH-1:0] sub3_hi_s;

  bcd_sub3_correct u_sub3 (
    .din  (hi_r),
    .dout (sub3_hi_s)
  );

  // Logical right shift of the 64-bit {hi, lo} work register.
  always_comb begin
    shift_hi_s = {1'b0, hi_r[BCD_WIDTH-1:1]};
    shift_lo_s = {hi_r[0], lo_r[BCD_WIDTH-1:1]};
  end

  // Conversion sequencer: capture on trigger, alternate shift/correct, publish result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      counter_r <= 6'd0;
      bad_r     <= 1'b0;
      idle_r    <= 1'b1;
      out_r     <= 32'd0;
      error_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (trigger) begin
            hi_r      <= bcd;
            lo_r      <= 32'd0;
            bad_r     <= has_bad_digit(bcd);
            counter_r <= 6'd1;
            idle_r    <= 1'b0;
            state_r   <= S_SHIFT;
          end else begin
            idle_r  <= 1'b1;
            state_r <= S_IDLE;
          end
        end
        S_SHIFT: begin
          hi_r <= shift_hi_s;
          lo_r <= shift_lo_s;
          if (counter_r == SHIFT_COUNT) begin
            // Invalid digits still run the full sequence so latency never varies.
            out_r   <= bad_r ? 32'd0 : shift_lo_s;
            error_r <= bad_r;
            idle_r  <= 1'b1;
            state_r <= S_IDLE;
          end else begin
            counter_r <= counter_r + 6'd1;
            state_r   <= S_SUB3;
          end
        end
        S_SUB3: begin
          hi_r    <= sub3_hi_s;
          state_r <= S_SHIFT;
        end
        default: begin
          // Any corrupted encoding recovers to a safe idle state.
          idle_r  <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign idle  = idle_r;
  assign out   = out_r;
  assign error = error_r;

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Directed scoreboard bench for bcd_to_unsigned.
module tb_bcd_to_unsigned;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic [31:0] bcd;
  logic        idle;
  logic [31:0] out;
  logic        error;

  typedef struct {
    logic [31:0] val;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   busy_cnt;

  bcd_to_unsigned dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd     (bcd),
    .idle    (idle),
    .out     (out),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (idle === 1'b0) busy_cnt++;
  endtask

  // One-cycle trigger; expectation pushed when stimulus is driven.
  task automatic start_conv(input logic [31:0] v, input logic [31:0] exp_val, input logic exp_err);
    exp_t e;
    @(negedge clk);
    bcd     = v;
    trigger = 1'b1;
    e.val = exp_val;
    e.err = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    trigger  = 1'b0;
    busy_cnt = (idle === 1'b0) ? 1 : 0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int guard;
    guard = 0;
    while (idle !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check({tag, "_latency"}, busy_cnt, 32'd63);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_out"}, out, e.val);
      check({tag, "_err"}, {31'd0, error}, {31'd0, e.err});
    end
  endtask

  initial begin
    exp_t e;
    checks   = 0;
    errors   = 0;
    busy_cnt = 0;
    reset    = 1'b1;
    trigger  = 1'b0;
    bcd      = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_out", out, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);

    start_conv(32'h0000_0000, 32'h0000_0000, 1'b0); wait_done("zero");
    start_conv(32'h1234_5678, 32'h00BC_614E, 1'b0); wait_done("seq");
    start_conv(32'h9999_9999, 32'h05F5_E0FF, 1'b0); wait_done("max");
    start_conv(32'h0000_0001, 32'h0000_0001, 1'b0); wait_done("one");
    start_conv(32'h0000_000A, 32'h0000_0000, 1'b1); wait_done("bad_lo");
    start_conv(32'hF000_0000, 32'h0000_0000, 1'b1); wait_done("bad_hi");
    start_conv(32'h0000_0042, 32'h0000_002A, 1'b0); wait_done("recover");

    // Trigger and bcd activity while busy must not disturb the conversion.
    start_conv(32'h0000_0500, 32'h0000_01F4, 1'b0);
    for (int i = 0; i < 10; i++) begin
      trigger = i[0];
      bcd     = 32'h9999_9999;
      tick();
    end
    trigger = 1'b0;
    check("busy_hold_out", out, 32'h0000_002A);
    check("busy_idle", {31'd0, idle}, 32'd0);
    wait_done("ignore");

    // Trigger held high: back-to-back conversions with one idle cycle between.
    @(negedge clk);
    bcd     = 32'h0000_0007;
    trigger = 1'b1;
    e.val = 32'h0000_0007;
    e.err = 1'b0;
    sb_q.push_back(e);
    @(negedge clk);
    busy_cnt = (idle === 1'b0) ? 1 : 0;
    bcd = 32'h0000_0012;
    wait_done("b2b_first");
    check("b2b_gap_idle", {31'd0, idle}, 32'd1);
    e.val = 32'h0000_000C;
    e.err = 1'b0;
    sb_q.push_back(e);
    busy_cnt = 0;
    tick();
    trigger = 1'b0;
    check("b2b_restart", {31'd0, idle}, 32'd0);
    wait_done("b2b_second");

    // Reset in the middle of a conversion discards everything.
    start_conv(32'h1234_5678, 32'h0, 1'b0);
    void'(sb_q.pop_back());
    repeat (19) tick();
    check("pre_rst_busy", busy_cnt, 32'd20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_idle", {31'd0, idle}, 32'd1);
    check("mid_rst_out", out, 32'd0);
    check("mid_rst_err", {31'd0, error}, 32'd0);
    start_conv(32'h0000_0255, 32'h0000_00FF, 1'b0); wait_done("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
